// File: rtl/l2_controller.sv
// ---------------------------------------------------------------------------
// l2_controller
//   Tag/state controller for a 2-way, 256-set unified L2 cache. It serves
//   L1 line reads (allocate) and line write-backs (dirty eviction), resolves
//   hit/miss against its own tag array, and evicts to or refills from main
//   memory when needed. Each request is answered with a one-cycle
//   ready_L2_L1 pulse. It also drives capture strobes to the L2 data array.
//
// Ports
//   clk, nrst            clock, asynchronous active-low reset
//   read_L1_L2           L1 line read request (level), {tag_L1_L2, index_L1_L2}
//   write_L1_L2          L1 write-back request (level),
//                        {write_tag_L1_L2, write_index_L1_L2}
//   flush                invalidate every line, honoured only when idle
//   ready_L2_L1          one-cycle completion pulse to L1
//   l2_refill            data array captures the memory line (pulse)
//   l2_update            data array captures the L1 write-back line (pulse)
//   l2_way, l2_index     selected way and latched request set
//   read_L2_MEM          memory line read (level)
//   write_L2_MEM         memory line write (level)
//   addr_L2_MEM          {victim tag, index} while writing back, else
//                        {request tag, index}
//   ready_MEM_L2         memory completion pulse
//   L2_miss_o            one-cycle pulse per miss
// ---------------------------------------------------------------------------
module l2_controller #(
  parameter int HIT_LATENCY = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        read_L1_L2,
  input  logic [17:0] tag_L1_L2,
  input  logic [7:0]  index_L1_L2,
  input  logic        write_L1_L2,
  input  logic [17:0] write_tag_L1_L2,
  input  logic [7:0]  write_index_L1_L2,
  input  logic        flush,
  output logic        ready_L2_L1,
  output logic        l2_refill,
  output logic        l2_update,
  output logic        l2_way,
  output logic [7:0]  l2_index,
  output logic        read_L2_MEM,
  output logic        write_L2_MEM,
  output logic [25:0] addr_L2_MEM,
  input  logic        ready_MEM_L2,
  output logic        L2_miss_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMPARE,
    S_WRITE_BACK,
    S_ALLOCATE,
    S_ACCESS,
    S_RELEASE
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(HIT_LATENCY - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [17:0] req_tag;
  logic [17:0] victim_tag;
  logic        req_is_write;

  // Storage: entry number is {index, way}
  logic [17:0] tag_arr [512];
  logic [511:0] valid;
  logic [511:0] dirty;
  logic [255:0] lru;

  // Lookup against the latched request address
  logic [8:0] entry0;
  logic [8:0] entry1;
  logic [8:0] sel_entry;
  logic [8:0] cur_entry;
  logic       hit0;
  logic       hit1;
  logic       is_hit;
  logic       sel_way;

  // Way choice: hit way, else first invalid way, else the LRU victim.
  always_comb begin
    entry0  = {l2_index, 1'b0};
    entry1  = {l2_index, 1'b1};
    hit0    = valid[entry0] && (tag_arr[entry0] == req_tag);
    hit1    = valid[entry1] && (tag_arr[entry1] == req_tag);
    is_hit  = hit0 | hit1;
    if (hit0)
      sel_way = 1'b0;
    else if (hit1)
      sel_way = 1'b1;
    else if (!valid[entry0])
      sel_way = 1'b0;
    else if (!valid[entry1])
      sel_way = 1'b1;
    else
      sel_way = lru[l2_index];
    sel_entry = {l2_index, sel_way};
  end

  // Entry picked in S_COMPARE, used by the memory phases and S_ACCESS
  assign cur_entry = {l2_index, l2_way};

  // The victim tag is latched in S_COMPARE so the write-back address is a
  // plain register mux.
  assign addr_L2_MEM = (state == S_WRITE_BACK) ? {victim_tag, l2_index}
                                               : {req_tag, l2_index};

  // Main controller: state, storage updates and registered outputs
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      req_tag      <= '0;
      victim_tag   <= '0;
      req_is_write <= 1'b0;
      l2_index     <= '0;
      l2_way       <= 1'b0;
      ready_L2_L1  <= 1'b0;
      l2_refill    <= 1'b0;
      l2_update    <= 1'b0;
      read_L2_MEM  <= 1'b0;
      write_L2_MEM <= 1'b0;
      L2_miss_o    <= 1'b0;
      valid        <= '0;
      dirty        <= '0;
      lru          <= '0;
      for (int i = 0; i < 512; i++) tag_arr[i] <= '0;
    end else begin
      // Pulse outputs default low; each is raised for exactly one cycle
      ready_L2_L1 <= 1'b0;
      l2_refill   <= 1'b0;
      l2_update   <= 1'b0;
      L2_miss_o   <= 1'b0;

      case (state)
        S_IDLE: begin
          if (flush) begin
            // Dirty lines are discarded, not written back
            valid <= '0;
            dirty <= '0;
          end else if (write_L1_L2) begin
            req_tag      <= write_tag_L1_L2;
            l2_index     <= write_index_L1_L2;
            req_is_write <= 1'b1;
            state        <= S_COMPARE;
          end else if (read_L1_L2) begin
            req_tag      <= tag_L1_L2;
            l2_index     <= index_L1_L2;
            req_is_write <= 1'b0;
            state        <= S_COMPARE;
          end
        end

        S_COMPARE: begin
          l2_way     <= sel_way;
          victim_tag <= tag_arr[sel_entry];
          if (is_hit) begin
            if (req_is_write) dirty[sel_entry] <= 1'b1;
            l2_update <= req_is_write;
            state     <= S_ACCESS;
          end else begin
            L2_miss_o <= 1'b1;
            if (valid[sel_entry] && dirty[sel_entry]) begin
              write_L2_MEM <= 1'b1;
              state        <= S_WRITE_BACK;
            end else if (!req_is_write) begin
              read_L2_MEM <= 1'b1;
              state       <= S_ALLOCATE;
            end else begin
              // Write miss with a clean victim installs immediately
              tag_arr[sel_entry] <= req_tag;
              valid[sel_entry]   <= 1'b1;
              dirty[sel_entry]   <= 1'b1;
              l2_update          <= 1'b1;
              state              <= S_ACCESS;
            end
          end
        end

        S_WRITE_BACK: begin
          if (ready_MEM_L2) begin
            write_L2_MEM <= 1'b0;
            if (req_is_write) begin
              tag_arr[cur_entry] <= req_tag;
              valid[cur_entry]   <= 1'b1;
              dirty[cur_entry]   <= 1'b1;
              l2_update          <= 1'b1;
              state              <= S_ACCESS;
            end else begin
              dirty[cur_entry] <= 1'b0;
              read_L2_MEM      <= 1'b1;
              state            <= S_ALLOCATE;
            end
          end
        end

        S_ALLOCATE: begin
          if (ready_MEM_L2) begin
            read_L2_MEM        <= 1'b0;
            tag_arr[cur_entry] <= req_tag;
            valid[cur_entry]   <= 1'b1;
            dirty[cur_entry]   <= 1'b0;
            l2_refill          <= 1'b1;
            state              <= S_ACCESS;
          end
        end

        S_ACCESS: begin
          // The way just used becomes most recently used
          if (cnt == 4'd0) lru[l2_index] <= ~l2_way;
          if (cnt == LAST_CNT) begin
            cnt         <= '0;
            ready_L2_L1 <= 1'b1;
            state       <= S_RELEASE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        S_RELEASE: begin
          // Wait for the L1 to drop the line it was served on; it lowers the
          // request one cycle after seeing ready.
          if (req_is_write ? !write_L1_L2 : !read_L1_L2) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
